lupdate: RTL and testbench
==========================

Name: lupdate

Overview:
- Sits directly downstream of the local report stage, on the path toward the network.
- Passes all packets through a fixed 3-cycle pipeline.
- Identifies beacon-update messages that the CNC addresses to this node. It consumes them (they are not forwarded), latches the configuration fields they carry, and toggles beacon_update_master so the report stage's next beacon carries msg type 4'hE as the acknowledgement.

Parameters:
- DFLT_TOKEN_BUCKET, 32'h0, reset value of token_bucket_para
- DFLT_SLOT_PERIOD, 32'd1000, reset value of time_slot_period
- UPD_MSG_TYPE, 4'hD, msg-type nibble that marks a beacon update

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- in_data_wr  in  1  input word strobe
- in_data  in  134  [133:132] 01=first/11=middle/10=last, [131:128] rsvd, [127:0] payload
- in_data_valid  in  1  packet-valid flag, qualified by in_data_valid_wr
- in_data_valid_wr  in  1  strobe for in_data_valid; asserted with the last word
- in_local_mac_id  in  48  this node's MAC
- out_data_wr  out  1  output word strobe
- out_data  out  134  forwarded word
- out_data_valid  out  1  aligned copy of in_data_valid
- out_data_valid_wr  out  1  aligned copy of in_data_valid_wr
- beacon_update_master  out  1  toggles once per applied update
- direction  out  1  latched config
- token_bucket_para  out  32  latched config
- direct_mac_addr  out  48  latched config
- time_slot_period  out  32  latched config
- upd_cnt  out  32  applied-update count, wraps
- upd_err_cnt  out  32  count of truncated update packets, wraps

Behaviour:
- Reset:
  - All out_* signals 0.
  - beacon_update_master 0, direction 0, direct_mac_addr 0.
  - token_bucket_para = DFLT_TOKEN_BUCKET; time_slot_period = DFLT_SLOT_PERIOD.
  - Both counters 0; pipeline empty; word index 0.
  - Reset asserted mid-packet discards the in-flight words; the next packet is accepted only from its first word (01).
- Word index:
  - 4-bit, counts in_data_wr words within a packet.
  - Cleared on a first word; saturates at 15.
- Pipeline:
  - Three stages. Each stage holds {wr, data, valid, valid_wr, drop}.
  - A word presented at cycle t appears on out_* at t+3 unless its drop bit is set. A dropped word emits out_data_wr=0, out_data=0 and valid/valid_wr=0.
  - Idle cycles (wr=0) propagate as bubbles.
- Classification, evaluated when index-2 word (Ethernet header) is accepted:
  - The packet is an update when all of the following hold:
    - dmac = data[127:80] equals in_local_mac_id;
    - ethertype = data[31:16] equals 16'h88f7;
    - data[11:8] equals UPD_MSG_TYPE.
  - On a match:
    - set drop on this word and on the stages holding words 0 and 1 of the same packet;
    - assert a sticky drop flag for the remaining words.
  - The sticky flag clears after the last word (10) is accepted.
- Field capture, on the index-6 word of an update packet:
  - data[127:80] -> direct_mac_addr shadow
  - data[79] -> direction shadow
  - data[63:32] -> token_bucket_para shadow
  - data[31:0] -> time_slot_period shadow
- Commit, on the last word of an update packet:
  - If index >= 6, the shadows are copied to the outputs, beacon_update_master toggles and upd_cnt increments, all in the same cycle.
  - Otherwise nothing is committed, upd_err_cnt increments, and the packet is still dropped.
- Boundary cases:
  - Packet shorter than 3 words: never classified, forwarded unchanged.
  - Back-to-back packets: drop bits are per stage, so the following packet's words are unaffected.
  - A first word (01) arriving while the sticky flag is set: the new packet restarts at index 0 and the sticky flag clears. Commit/error rules then apply only if that new packet is itself an update.
  - Counters wrap from 32'hFFFFFFFF to 0.
  - Config outputs change only on a commit.

Decomposition:
- Shared package lcm_pkg holds:
  - header codes HDR_FIRST=2'b01, HDR_MID=2'b11, HDR_LAST=2'b10;
  - PTP_ETHERTYPE=16'h88f7;
  - msg types MSG_REPORT=4'hF, MSG_ACK=4'hE, MSG_UPDATE=4'hD;
  - word indices ETH_WORD=2, BEACON_WORD=6;
  - CNC_MAC=48'h010203040506;
  - beacon field bit positions.
- One natural sub-module, lupdate_pipe: a 3-stage delay line with a per-stage drop bit and a retroactive drop-mark input.
- Parser FSM and registers live in the top level.

Test Plan:
- Non-update 8-word packet, ethertype 0x0800, back-to-back with a 4-word packet: both appear unchanged at t+3; upd_cnt stays 0.
- Update packet, 13 words, dmac=in_local_mac_id=48'h000606020000, word 6 = {48'hAABBCCDDEEFF, 1'b1, 15'b0, 32'h00010002, 32'd500}:
  - no out_data_wr for the whole packet;
  - after the last word, direct_mac_addr=48'hAABBCCDDEEFF, direction=1, token_bucket_para=32'h00010002, time_slot_period=500;
  - beacon_update_master 0->1; upd_cnt=1.
- Same update sent with dmac=CNC_MAC: forwarded intact; config and counters unchanged.
- 5-word update packet (last at index 4): dropped; upd_err_cnt=1; config unchanged; beacon_update_master unchanged.
- Two update packets back-to-back: beacon_update_master returns to 0; upd_cnt=2; second packet's fields visible.
- rst_n pulsed during word 4 of an update, then a normal 3-word packet: config at defaults (time_slot_period=1000); normal packet forwarded at t+3.

Source files
------------

// File: rtl/lcm_pkg.sv
// Shared constants and types for the local control path: word header codes,
// beacon field positions and the pipeline stage record.
package lcm_pkg;

    localparam int W_DATA = 134;

    localparam logic [1:0] HDR_FIRST = 2'b01;
    localparam logic [1:0] HDR_MID   = 2'b11;
    localparam logic [1:0] HDR_LAST  = 2'b10;

    localparam logic [15:0] PTP_ETHERTYPE = 16'h88f7;

    localparam logic [3:0] MSG_REPORT = 4'hF;
    localparam logic [3:0] MSG_ACK    = 4'hE;
    localparam logic [3:0] MSG_UPDATE = 4'hD;

    localparam logic [3:0] ETH_WORD    = 4'd2;
    localparam logic [3:0] BEACON_WORD = 4'd6;

    localparam logic [47:0] CNC_MAC = 48'h010203040506;

    localparam int HDR_HI   = 133;
    localparam int HDR_LO   = 132;
    localparam int DMAC_HI  = 127;
    localparam int DMAC_LO  = 80;
    localparam int ETYPE_HI = 31;
    localparam int ETYPE_LO = 16;
    localparam int MSG_HI   = 11;
    localparam int MSG_LO   = 8;

    localparam int BCN_MAC_HI = 127;
    localparam int BCN_MAC_LO = 80;
    localparam int BCN_DIR    = 79;
    localparam int BCN_TB_HI  = 63;
    localparam int BCN_TB_LO  = 32;
    localparam int BCN_TS_HI  = 31;
    localparam int BCN_TS_LO  = 0;

    typedef struct packed {
        logic              wr;
        logic [W_DATA-1:0] data;
        logic              valid;
        logic              valid_wr;
        logic              drop;
    } stage_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PASS,
        ST_DROP
    } parse_state_e;

    function automatic logic [3:0] idx_inc(input logic [3:0] idx);
        return (idx == 4'hF) ? idx : idx + 4'd1;
    endfunction

endpackage

// File: rtl/lupdate_pipe.sv
// Three-stage delay line; each stage carries a drop bit that can be set
// retroactively on the two younger stages once a packet is classified.
module lupdate_pipe
    import lcm_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_wr,
    input  logic [W_DATA-1:0] in_data,
    input  logic              in_valid,
    input  logic              in_valid_wr,
    input  logic              in_drop,
    input  logic              mark_drop,
    output logic              out_wr,
    output logic [W_DATA-1:0] out_data,
    output logic              out_valid,
    output logic              out_valid_wr
);

    stage_t stage_q [3];
    stage_t stage_d [3];

    always_comb begin
        stage_d[0].wr       = in_wr;
        stage_d[0].data     = in_data;
        stage_d[0].valid    = in_valid;
        stage_d[0].valid_wr = in_valid_wr;
        stage_d[0].drop     = in_drop;
        // stage 2 is already on the outputs this cycle, so only 0 and 1 can be marked
        stage_d[1]          = stage_q[0];
        stage_d[1].drop     = stage_q[0].drop | mark_drop;
        stage_d[2]          = stage_q[1];
        stage_d[2].drop     = stage_q[1].drop | mark_drop;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stage_q[0] <= '0;
            stage_q[1] <= '0;
            stage_q[2] <= '0;
        end else begin
            stage_q[0] <= stage_d[0];
            stage_q[1] <= stage_d[1];
            stage_q[2] <= stage_d[2];
        end
    end

    assign out_wr       = stage_q[2].wr & ~stage_q[2].drop;
    assign out_data     = stage_q[2].drop ? '0 : stage_q[2].data;
    assign out_valid    = stage_q[2].valid & ~stage_q[2].drop;
    assign out_valid_wr = stage_q[2].valid_wr & ~stage_q[2].drop;

endmodule

// File: rtl/lupdate.sv
// Beacon-update consumer: forwards traffic with fixed latency, swallows CNC
// update packets addressed to this node and commits their configuration.
//
// state   | meaning
// ST_IDLE | no packet open; waiting for a first word
// ST_PASS | inside a packet that is being forwarded
// ST_DROP | inside an update packet; words are swallowed
module lupdate
    import lcm_pkg::*;
#(
    parameter logic [31:0] DFLT_TOKEN_BUCKET = 32'h0,
    parameter logic [31:0] DFLT_SLOT_PERIOD  = 32'd1000,
    parameter logic [3:0]  UPD_MSG_TYPE      = MSG_UPDATE
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_data_wr,
    input  logic [W_DATA-1:0]  in_data,
    input  logic               in_data_valid,
    input  logic               in_data_valid_wr,
    input  logic [47:0]        in_local_mac_id,
    output logic               out_data_wr,
    output logic [W_DATA-1:0]  out_data,
    output logic               out_data_valid,
    output logic               out_data_valid_wr,
    output logic               beacon_update_master,
    output logic               direction,
    output logic [31:0]        token_bucket_para,
    output logic [47:0]        direct_mac_addr,
    output logic [31:0]        time_slot_period,
    output logic [31:0]        upd_cnt,
    output logic [31:0]        upd_err_cnt
);

    parse_state_e state_q, state_d;
    logic [3:0]   idx_q, idx_d;
    logic [47:0]  sh_mac_q, sh_mac_d, mac_q, mac_d;
    logic         sh_dir_q, sh_dir_d, dir_q, dir_d;
    logic [31:0]  sh_tb_q, sh_tb_d, tb_q, tb_d;
    logic [31:0]  sh_ts_q, sh_ts_d, ts_q, ts_d;
    logic         bum_q, bum_d;
    logic [31:0]  cnt_q, cnt_d, err_q, err_d;

    logic [1:0]   hdr;
    logic         is_first, is_last, hdr_match, drop_in, mark;
    logic [3:0]   cur_idx;

    always_comb begin
        hdr       = in_data[HDR_HI:HDR_LO];
        is_first  = in_data_wr && (hdr == HDR_FIRST);
        is_last   = in_data_wr && (hdr == HDR_LAST);
        cur_idx   = is_first ? 4'd0 : idx_q;
        hdr_match = (in_data[DMAC_HI:DMAC_LO] == in_local_mac_id)
                 && (in_data[ETYPE_HI:ETYPE_LO] == PTP_ETHERTYPE)
                 && (in_data[MSG_HI:MSG_LO] == UPD_MSG_TYPE);

        state_d  = state_q;
        idx_d    = idx_q;
        drop_in  = 1'b0;
        mark     = 1'b0;
        sh_mac_d = sh_mac_q;
        sh_dir_d = sh_dir_q;
        sh_tb_d  = sh_tb_q;
        sh_ts_d  = sh_ts_q;
        mac_d    = mac_q;
        dir_d    = dir_q;
        tb_d     = tb_q;
        ts_d     = ts_q;
        bum_d    = bum_q;
        cnt_d    = cnt_q;
        err_d    = err_q;

        if (in_data_wr)
            idx_d = is_first ? 4'd1 : idx_inc(idx_q);

        // a first word always restarts parsing, abandoning any open update
        if (is_first) begin
            state_d = ST_PASS;
        end else begin
            case (state_q)
                ST_PASS: begin
                    if (in_data_wr && cur_idx == ETH_WORD && hdr_match) begin
                        drop_in = 1'b1;
                        mark    = 1'b1;
                        state_d = ST_DROP;
                        if (is_last) begin
                            err_d   = err_q + 32'd1;
                            state_d = ST_IDLE;
                        end
                    end else if (is_last) begin
                        state_d = ST_IDLE;
                    end
                end
                ST_DROP: begin
                    drop_in = 1'b1;
                    if (in_data_wr && cur_idx == BEACON_WORD) begin
                        sh_mac_d = in_data[BCN_MAC_HI:BCN_MAC_LO];
                        sh_dir_d = in_data[BCN_DIR];
                        sh_tb_d  = in_data[BCN_TB_HI:BCN_TB_LO];
                        sh_ts_d  = in_data[BCN_TS_HI:BCN_TS_LO];
                    end
                    if (is_last) begin
                        state_d = ST_IDLE;
                        // commit from the _d shadows so a last word at index 6 is captured too
                        if (cur_idx >= BEACON_WORD) begin
                            mac_d = sh_mac_d;
                            dir_d = sh_dir_d;
                            tb_d  = sh_tb_d;
                            ts_d  = sh_ts_d;
                            bum_d = ~bum_q;
                            cnt_d = cnt_q + 32'd1;
                        end else begin
                            err_d = err_q + 32'd1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            idx_q    <= '0;
            sh_mac_q <= '0;
            sh_dir_q <= 1'b0;
            sh_tb_q  <= DFLT_TOKEN_BUCKET;
            sh_ts_q  <= DFLT_SLOT_PERIOD;
            mac_q    <= '0;
            dir_q    <= 1'b0;
            tb_q     <= DFLT_TOKEN_BUCKET;
            ts_q     <= DFLT_SLOT_PERIOD;
            bum_q    <= 1'b0;
            cnt_q    <= '0;
            err_q    <= '0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            sh_mac_q <= sh_mac_d;
            sh_dir_q <= sh_dir_d;
            sh_tb_q  <= sh_tb_d;
            sh_ts_q  <= sh_ts_d;
            mac_q    <= mac_d;
            dir_q    <= dir_d;
            tb_q     <= tb_d;
            ts_q     <= ts_d;
            bum_q    <= bum_d;
            cnt_q    <= cnt_d;
            err_q    <= err_d;
        end
    end

    lupdate_pipe u_pipe (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_wr        (in_data_wr),
        .in_data      (in_data),
        .in_valid     (in_data_valid),
        .in_valid_wr  (in_data_valid_wr),
        .in_drop      (drop_in),
        .mark_drop    (mark),
        .out_wr       (out_data_wr),
        .out_data     (out_data),
        .out_valid    (out_data_valid),
        .out_valid_wr (out_data_valid_wr)
    );

    assign beacon_update_master = bum_q;
    assign direction            = dir_q;
    assign token_bucket_para    = tb_q;
    assign direct_mac_addr      = mac_q;
    assign time_slot_period     = ts_q;
    assign upd_cnt              = cnt_q;
    assign upd_err_cnt          = err_q;

endmodule

// File: tb/tb_lupdate.sv
// Bench for lupdate: directed and random packets against a packet-level model
// that decides forward/swallow and config effects per whole packet.
module tb_lupdate;

    localparam logic [47:0] LOCAL_MAC = 48'h000606020000;
    localparam logic [47:0] CNC       = 48'h010203040506;

    logic         clk = 1'b0;
    logic         rst_n = 1'b1;
    logic         in_data_wr = 1'b0;
    logic [133:0] in_data = '0;
    logic         in_data_valid = 1'b0;
    logic         in_data_valid_wr = 1'b0;
    logic [47:0]  in_local_mac_id = LOCAL_MAC;
    logic         out_data_wr;
    logic [133:0] out_data;
    logic         out_data_valid;
    logic         out_data_valid_wr;
    logic         beacon_update_master;
    logic         direction;
    logic [31:0]  token_bucket_para;
    logic [47:0]  direct_mac_addr;
    logic [31:0]  time_slot_period;
    logic [31:0]  upd_cnt;
    logic [31:0]  upd_err_cnt;

    always #5 clk = ~clk;

    lupdate dut (
        .clk                  (clk),
        .rst_n                (rst_n),
        .in_data_wr           (in_data_wr),
        .in_data              (in_data),
        .in_data_valid        (in_data_valid),
        .in_data_valid_wr     (in_data_valid_wr),
        .in_local_mac_id      (in_local_mac_id),
        .out_data_wr          (out_data_wr),
        .out_data             (out_data),
        .out_data_valid       (out_data_valid),
        .out_data_valid_wr    (out_data_valid_wr),
        .beacon_update_master (beacon_update_master),
        .direction            (direction),
        .token_bucket_para    (token_bucket_para),
        .direct_mac_addr      (direct_mac_addr),
        .time_slot_period     (time_slot_period),
        .upd_cnt              (upd_cnt),
        .upd_err_cnt          (upd_err_cnt)
    );

    int checks = 0;
    int errors = 0;

    logic [136:0] exp_q [$];
    logic [127:0] pkt [16];
    int           pkt_len;

    logic [47:0] m_mac;
    logic        m_dir;
    logic [31:0] m_tb, m_ts, m_cnt, m_err;
    logic        m_bum;

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_mac = '0; m_dir = 1'b0; m_tb = 32'h0; m_ts = 32'd1000;
        m_cnt = '0; m_err = '0; m_bum = 1'b0;
        exp_q.delete();
        repeat (3) exp_q.push_back('0);
    endtask

    // one clock: check what should be leaving now, then present the next input
    task automatic step(input logic wr, input logic [133:0] d, input logic v,
                        input logic vwr, input logic swallow);
        logic [136:0] o, e;
        @(negedge clk);
        o = {out_data_wr, out_data, out_data_valid, out_data_valid_wr};
        e = exp_q.pop_front();
        chk("out", o, e);
        in_data_wr = wr; in_data = d; in_data_valid = v; in_data_valid_wr = vwr;
        exp_q.push_back(swallow ? 137'd0 : {wr, d, v, vwr});
    endtask

    task automatic make_pkt(input int len, input logic [47:0] dmac, input logic [15:0] et,
                            input logic [3:0] msg, input logic [127:0] w6);
        pkt_len = len;
        for (int i = 0; i < 16; i++) pkt[i] = {$urandom, $urandom, $urandom, $urandom};
        pkt[2][127:80] = dmac;
        pkt[2][31:16]  = et;
        pkt[2][11:8]   = msg;
        pkt[6]         = w6;
    endtask

    task automatic send_pkt(input int gap);
        logic       upd, vflag, last;
        logic [1:0] hdr;
        upd   = (pkt_len >= 3) && (pkt[2][127:80] == LOCAL_MAC)
             && (pkt[2][31:16] == 16'h88f7) && (pkt[2][11:8] == 4'hD);
        vflag = 1'($urandom_range(0, 1));
        for (int i = 0; i < pkt_len; i++) begin
            last = (i == pkt_len - 1);
            hdr  = (i == 0) ? 2'b01 : (last ? 2'b10 : 2'b11);
            step(1'b1, {hdr, 4'b0, pkt[i]}, last ? vflag : 1'b0, last, upd);
        end
        if (upd) begin
            if (pkt_len >= 7) begin
                m_mac = pkt[6][127:80]; m_dir = pkt[6][79];
                m_tb  = pkt[6][63:32];  m_ts  = pkt[6][31:0];
                m_cnt = m_cnt + 32'd1;  m_bum = ~m_bum;
            end else begin
                m_err = m_err + 32'd1;
            end
        end
        for (int g = 0; g < gap; g++) step(1'b0, '0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic check_cfg(input string tag);
        repeat (3) step(1'b0, '0, 1'b0, 1'b0, 1'b0);
        chk({tag, ".mac"}, direct_mac_addr, m_mac);
        chk({tag, ".dir"}, direction, m_dir);
        chk({tag, ".tb"},  token_bucket_para, m_tb);
        chk({tag, ".ts"},  time_slot_period, m_ts);
        chk({tag, ".cnt"}, upd_cnt, m_cnt);
        chk({tag, ".err"}, upd_err_cnt, m_err);
        chk({tag, ".bum"}, beacon_update_master, m_bum);
    endtask

    logic [127:0] w6a, w6b;
    logic [47:0]  rmac;
    logic [15:0]  ret;
    logic [3:0]   rmsg;

    initial begin
        w6a = {48'hAABBCCDDEEFF, 1'b1, 15'b0, 32'h00010002, 32'd500};
        w6b = {48'h112233445566, 1'b0, 15'b0, 32'hDEAD0001, 32'd77};

        #2 rst_n = 1'b0;
        model_reset();
        #20;
        chk("rst.out", {out_data_wr, out_data, out_data_valid, out_data_valid_wr}, 137'd0);
        @(negedge clk);
        rst_n = 1'b1;
        check_cfg("rst");

        make_pkt(8, LOCAL_MAC, 16'h0800, 4'hD, {$urandom, $urandom, $urandom, $urandom});
        send_pkt(0);
        make_pkt(4, 48'h123456789ABC, 16'h88f7, 4'hD, '0);
        send_pkt(0);
        check_cfg("b2b");

        make_pkt(13, LOCAL_MAC, 16'h88f7, 4'hD, w6a);
        send_pkt(1);
        check_cfg("upd13");

        make_pkt(13, CNC, 16'h88f7, 4'hD, w6b);
        send_pkt(1);
        check_cfg("cncdmac");

        make_pkt(5, LOCAL_MAC, 16'h88f7, 4'hD, w6b);
        send_pkt(1);
        check_cfg("short5");

        // reset lands while word 4 of an update is being presented
        make_pkt(13, LOCAL_MAC, 16'h88f7, 4'hD, w6b);
        for (int i = 0; i < 5; i++)
            step(1'b1, {(i == 0) ? 2'b01 : 2'b11, 4'b0, pkt[i]}, 1'b0, 1'b0, 1'b1);
        #2 rst_n = 1'b0;
        in_data_wr = 1'b0; in_data = '0; in_data_valid = 1'b0; in_data_valid_wr = 1'b0;
        model_reset();
        @(negedge clk);
        chk("midrst.out", {out_data_wr, out_data, out_data_valid, out_data_valid_wr}, 137'd0);
        rst_n = 1'b1;
        make_pkt(3, 48'h0A0B0C0D0E0F, 16'h0800, 4'h0, '0);
        send_pkt(0);
        check_cfg("midrst");

        make_pkt(9, LOCAL_MAC, 16'h88f7, 4'hD, w6a);
        send_pkt(0);
        make_pkt(7, LOCAL_MAC, 16'h88f7, 4'hD, w6b);
        send_pkt(0);
        check_cfg("twoupd");

        for (int n = 0; n < 48; n++) begin
            case ($urandom_range(0, 3))
                0: begin rmac = LOCAL_MAC; ret = 16'h88f7; rmsg = 4'hD; end
                1: begin rmac = CNC;       ret = 16'h88f7; rmsg = 4'hD; end
                2: begin rmac = LOCAL_MAC; ret = ($urandom_range(0, 1) != 0) ? 16'h0800 : 16'h88f7;
                         rmsg = ($urandom_range(0, 1) != 0) ? 4'hE : 4'hF; end
                default: begin rmac = {$urandom, 16'h0}; ret = 16'($urandom); rmsg = 4'($urandom); end
            endcase
            make_pkt($urandom_range(2, 14), rmac, ret, rmsg, {$urandom, $urandom, $urandom, $urandom});
            send_pkt($urandom_range(0, 2));
            if (n % 8 == 7) check_cfg("rand");
        end
        check_cfg("final");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
